// File: rtl/fifo_wr_arbiter.sv
// Round-robin, frame-locked arbiter sharing one async-FIFO write port (WClk domain)
// between NUM_REQ sources. An owner keeps the port for FRAME_LEN words, so a stereo
// frame is never split. A stalled owner is dropped after TIMEOUT idle cycles. The
// module also keeps a saturating count of cycles lost to a full FIFO.
//
// state | meaning
// IDLE  | no owner; pick the next requester in rotation (no write this cycle)
// BURST | owner registered; forward its words until FRAME_LEN written or timeout
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 2,
  parameter int TIMEOUT    = 8
) (
  input  logic                          PresetFull,
  input  logic                          WClk,
  input  logic [NUM_REQ-1:0]            Req_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_in,
  output logic [NUM_REQ-1:0]            Ack_out,
  input  logic                          FifoFull_in,
  output logic                          FifoWriteEn_out,
  output logic [DATA_WIDTH-1:0]         FifoData_out,
  output logic [NUM_REQ-1:0]            Grant_out,
  output logic                          FrameAbort_out,
  input  logic                          StatClear_in,
  output logic [15:0]                   StallCount_out
);

  localparam int OW  = $clog2(NUM_REQ);
  localparam int WCW = $clog2(FRAME_LEN + 1);
  localparam int ICW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WC_LAST = WCW'(FRAME_LEN - 1);
  localparam logic [ICW-1:0] IC_LAST = ICW'(TIMEOUT - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, last_owner, pick, cand;
  logic            pick_valid;
  logic [WCW-1:0]  word_cnt;
  logic [ICW-1:0]  idle_cnt;
  logic            req_owner;
  logic            write_en;
  logic            abort;
  logic            frame_done;

  assign req_owner  = Req_in[owner];
  assign frame_done = write_en && (word_cnt == WC_LAST);

  // Rotating priority search starting just after the previous owner.
  always_comb begin
    pick       = last_owner;
    cand       = last_owner;
    pick_valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = OW'((int'(last_owner) + i) % NUM_REQ);
      if (!pick_valid && Req_in[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge WClk or posedge PresetFull) begin
    if (PresetFull) state <= IDLE;
    else            state <= state_nxt;
  end

  // FSM next-state: leave BURST on the last word of a frame or on timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = BURST;
      BURST:   if (frame_done || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: write path is combinational from the owner's request and FIFO full.
  always_comb begin
    write_en        = 1'b0;
    abort           = 1'b0;
    Grant_out       = '0;
    Ack_out         = '0;
    FifoData_out    = Data_in[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    if (state == BURST) begin
      write_en  = req_owner & ~FifoFull_in;
      abort     = ~req_owner && (idle_cnt == IC_LAST);
      Grant_out = NUM_REQ'(1) << owner;
      if (write_en) Ack_out = NUM_REQ'(1) << owner;
    end
    FifoWriteEn_out = write_en;
    FrameAbort_out  = abort;
  end

  // Owner, rotation pointer, word and idle counters.
  always_ff @(posedge WClk or posedge PresetFull) begin
    if (PresetFull) begin
      owner      <= '0;
      last_owner <= OW'(NUM_REQ - 1);
      word_cnt   <= '0;
      idle_cnt   <= '0;
    end else if (state == IDLE) begin
      word_cnt <= '0;
      idle_cnt <= '0;
      if (pick_valid) owner <= pick;
    end else if (write_en) begin
      idle_cnt <= '0;
      if (frame_done) begin
        word_cnt   <= '0;
        last_owner <= owner;
      end else begin
        word_cnt <= word_cnt + WCW'(1);
      end
    end else if (!req_owner) begin
      if (abort) begin
        idle_cnt   <= '0;
        word_cnt   <= '0;
        last_owner <= owner;
      end else begin
        idle_cnt <= idle_cnt + ICW'(1);
      end
    end
    // Owner requesting but FIFO full: word_cnt and idle_cnt both hold.
  end

  // Saturating full-stall counter; clear wins over increment.
  always_ff @(posedge WClk or posedge PresetFull) begin
    if (PresetFull) begin
      StallCount_out <= '0;
    end else if (StatClear_in) begin
      StallCount_out <= '0;
    end else if ((state == BURST) && req_owner && FifoFull_in &&
                 (StallCount_out != 16'hFFFF)) begin
      StallCount_out <= StallCount_out + 16'd1;
    end
  end

endmodule
